// File: rtl/pop_count_pipe_if.sv
// Valid/ready stream bundle for pop_count_pipe.
// slave = the counter, master = producer/consumer side.
interface pop_count_pipe_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 16
);
  localparam int OUT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_count;
  logic             acc_clr;
  logic [ACC_W-1:0] acc_total;

  modport slave (
    input  in_valid, in_data, in_mode,
    input  out_ready, acc_clr,
    output in_ready, out_valid,
    output out_count, acc_total
  );

  modport master (
    output in_valid, in_data, in_mode,
    output out_ready, acc_clr,
    input  in_ready, out_valid,
    input  out_count, acc_total
  );
endinterface

// File: rtl/pop_count_pipe.sv
// 3-register pipelined popcount (ones or zeros) with global stall.
// Optional running total of results when POP_CNT_ACC_EN is defined.
module pop_count_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int ACC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pop_count_pipe_if.slave bus
);
  localparam int OUT_W = $clog2(WIDTH + 1);
  localparam int NCH   = WIDTH / CHUNK;
  localparam int CW    = $clog2(CHUNK + 1);

  if ((WIDTH % CHUNK) != 0 ||
      !(CHUNK == 4 || CHUNK == 8)) begin : g_bad_cfg
    $error("pop_count_pipe: illegal WIDTH/CHUNK");
  end

  logic                      s1_v_q, s1_v_d;
  logic [WIDTH-1:0]          s1_data_q, s1_data_d;
  logic                      s1_mode_q, s1_mode_d;
  logic                      s2_v_q, s2_v_d;
  logic [NCH-1:0][CW-1:0]    s2_cnt_q, s2_cnt_d;
  logic                      out_v_q, out_v_d;
  logic [OUT_W-1:0]          out_cnt_q, out_cnt_d;

  logic                      stall;
  logic [WIDTH-1:0]          s1_word;
  logic [NCH-1:0][CW-1:0]    chunk_cnt;
  logic [OUT_W-1:0]          chunk_sum;

  assign stall   = out_v_q & ~bus.out_ready;
  assign s1_word = s1_mode_q ? ~s1_data_q : s1_data_q;

  // Per-chunk bit counts of the (possibly inverted) S1 word
  always_comb begin
    chunk_cnt = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < CHUNK; b++) begin
        chunk_cnt[c] = chunk_cnt[c] + CW'(s1_word[c*CHUNK+b]);
      end
    end
  end

  // Adder tree over the registered chunk counts
  always_comb begin
    chunk_sum = '0;
    for (int c = 0; c < NCH; c++) begin
      chunk_sum = chunk_sum + OUT_W'(s2_cnt_q[c]);
    end
  end

  // Pipeline advance: everything moves together unless stalled
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_mode_d = s1_mode_q;
    s2_v_d    = s2_v_q;
    s2_cnt_d  = s2_cnt_q;
    out_v_d   = out_v_q;
    out_cnt_d = out_cnt_q;
    if (!stall) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = bus.in_data;
        s1_mode_d = bus.in_mode;
      end
      s2_v_d    = s1_v_q;
      s2_cnt_d  = chunk_cnt;
      out_v_d   = s2_v_q;
      out_cnt_d = chunk_sum;
    end
  end

  // Stage registers, all cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_mode_q <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_cnt_q  <= '0;
      out_v_q   <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_mode_q <= s1_mode_d;
      s2_v_q    <= s2_v_d;
      s2_cnt_q  <= s2_cnt_d;
      out_v_q   <= out_v_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_v_q;
  assign bus.out_count = out_cnt_q;

`ifdef POP_CNT_ACC_EN
  logic             xfer;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_q, acc_d;

  assign xfer    = out_v_q & bus.out_ready;
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(out_cnt_q);

  // Saturating total of transferred results; clear wins over add
  always_comb begin
    acc_d = acc_q;
    if (bus.acc_clr) begin
      acc_d = xfer ? ACC_W'(out_cnt_q) : '0;
    end else if (xfer) begin
      acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign bus.acc_total = acc_q;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = bus.acc_clr;
  assign bus.acc_total  = '0;
`endif
endmodule

// File: tb/tb_pop_count_pipe.sv
// Randomised and directed bench for pop_count_pipe.
// Three DUT widths run in lockstep against one slot-level model.
module tb_pop_count_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] din = '0;
  logic vin = 1'b0, mode = 1'b0;
  logic ordy = 1'b0, clr = 1'b0;

  pop_count_pipe_if #(.WIDTH(32), .ACC_W(8))  b32();
  pop_count_pipe_if #(.WIDTH(64), .ACC_W(16)) b64();
  pop_count_pipe_if #(.WIDTH(16), .ACC_W(16)) b16();

  assign b32.in_valid = vin;  assign b64.in_valid = vin;
  assign b16.in_valid = vin;
  assign b32.in_data = din[31:0]; assign b64.in_data = din;
  assign b16.in_data = din[15:0];
  assign b32.in_mode = mode;  assign b64.in_mode = mode;
  assign b16.in_mode = mode;
  assign b32.out_ready = ordy; assign b64.out_ready = ordy;
  assign b16.out_ready = ordy;
  assign b32.acc_clr = clr;   assign b64.acc_clr = clr;
  assign b16.acc_clr = clr;

  pop_count_pipe #(.WIDTH(32), .CHUNK(8), .ACC_W(8))
    u32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  pop_count_pipe #(.WIDTH(64), .CHUNK(4), .ACC_W(16))
    u64 (.clk(clk), .rst_n(rst_n), .bus(b64));
  pop_count_pipe #(.WIDTH(16), .CHUNK(8), .ACC_W(16))
    u16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int popc(input logic [63:0] d, input int w,
                              input logic m);
    int n = 0;
    for (int i = 0; i < w; i++) if (d[i] ^ m) n++;
    return n;
  endfunction

  // Model: three result slots that all move unless the last is stuck
  bit mv[3];
  int m32[3], m64[3], m16[3];
  int macc;
  int cyc = 0;
  int got[$];
  int gotcyc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mv[i]  <= 1'b0;
        m32[i] <= 0; m64[i] <= 0; m16[i] <= 0;
      end
      macc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (b32.out_valid && ordy) begin
        got.push_back(int'(b32.out_count));
        gotcyc.push_back(cyc);
      end
      if (!(mv[2] && !ordy)) begin
        mv[2] <= mv[1]; mv[1] <= mv[0]; mv[0] <= vin;
        m32[2] <= m32[1]; m32[1] <= m32[0];
        m64[2] <= m64[1]; m64[1] <= m64[0];
        m16[2] <= m16[1]; m16[1] <= m16[0];
        m32[0] <= popc(din, 32, mode);
        m64[0] <= popc(din, 64, mode);
        m16[0] <= popc(din, 16, mode);
      end
`ifdef POP_CNT_ACC_EN
      if (clr)
        macc <= (mv[2] && ordy) ? m32[2] : 0;
      else if (mv[2] && ordy)
        macc <= (macc + m32[2] > 255) ? 255 : macc + m32[2];
`endif
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      #2;
      chk("valid32", int'(b32.out_valid), int'(mv[2]));
      chk("valid64", int'(b64.out_valid), int'(mv[2]));
      chk("valid16", int'(b16.out_valid), int'(mv[2]));
      if (mv[2]) begin
        chk("count32", int'(b32.out_count), m32[2]);
        chk("count64", int'(b64.out_count), m64[2]);
        chk("count16", int'(b16.out_count), m16[2]);
      end
      chk("ready32", int'(b32.in_ready), int'(!(mv[2] && !ordy)));
      chk("ready64", int'(b64.in_ready), int'(!(mv[2] && !ordy)));
      chk("ready16", int'(b16.in_ready), int'(!(mv[2] && !ordy)));
      chk("acc32", int'(b32.acc_total), macc);
    end
  end

  task automatic cycle(input logic v, input logic [63:0] d,
                       input logic m, input logic r, input logic c,
                       output logic rdy);
    @(negedge clk);
    vin = v; din = d; mode = m; ordy = r; clr = c;
    #1 rdy = b32.in_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  logic rdy;
  int   e1[4] = '{32, 32, 2, 30};
  logic [63:0] w4[4] = '{64'h1, 64'h3, 64'h7, 64'hF};

  initial begin
    #3;
    chk("rst_valid", int'(b32.out_valid), 0);
    chk("rst_count", int'(b32.out_count), 0);
    chk("rst_acc", int'(b32.acc_total), 0);
    #9 rst_n = 1'b1;

    // Latency and basic values
    got.delete(); gotcyc.delete();
    cycle(1, 64'hFFFF_FFFF, 0, 1, 0, rdy);
    chk("lat_e0", int'(b32.out_valid), 0);
    cycle(1, 64'h0, 1, 1, 0, rdy);
    chk("lat_e1", int'(b32.out_valid), 0);
    cycle(1, 64'h8000_0001, 0, 1, 0, rdy);
    chk("lat_e2", int'(b32.out_valid), 1);
    chk("lat_cnt", int'(b32.out_count), 32);
    cycle(1, 64'h8000_0001, 1, 1, 0, rdy);
    repeat (4) cycle(0, 64'h0, 0, 1, 0, rdy);
    chk("p1_n", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk("p1_val", got[k], e1[k]);

    // Back-to-back stream
    got.delete(); gotcyc.delete();
    for (int k = 0; k < 4; k++) begin
      cycle(1, w4[k], 0, 1, 0, rdy);
      chk("p2_rdy", int'(rdy), 1);
    end
    repeat (4) cycle(0, 64'h0, 0, 1, 0, rdy);
    chk("p2_n", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      chk("p2_val", got[k], k + 1);
      chk("p2_cyc", gotcyc[k] - gotcyc[0], k);
    end

    // Backpressure while result 2 is shown
    begin
      int idx = 0, stalls = 0;
      bit seen = 0;
      logic r;
      got.delete(); gotcyc.delete();
      for (int n = 0; n < 20; n++) begin
        r = 1'b1;
        if (!seen && b32.out_valid && b32.out_count == 2) begin
          seen = 1; stalls = 3;
        end
        if (stalls > 0) begin
          r = 1'b0; stalls--;
          chk("p3_hold", int'(b32.out_count), 2);
        end
        cycle(idx < 4, (idx < 4) ? w4[idx] : 64'h0, 0, r, 0, rdy);
        if (!r) chk("p3_rdy", int'(rdy), 0);
        if (idx < 4 && rdy) idx++;
      end
      chk("p3_seen", int'(seen), 1);
      chk("p3_n", got.size(), 4);
      for (int k = 0; k < 4 && k < got.size(); k++)
        chk("p3_val", got[k], k + 1);
    end

    // Asynchronous reset with two words in flight
    cycle(1, 64'h1, 0, 1, 0, rdy);
    cycle(1, 64'h3, 0, 1, 0, rdy);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(b32.out_valid), 0);
    chk("ar_count", int'(b32.out_count), 0);
    got.delete(); gotcyc.delete();
    vin = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (6) cycle(0, 64'h0, 0, 1, 0, rdy);
    chk("ar_stale", got.size(), 0);

    // Random traffic with backpressure
    for (int n = 0; n < 600; n++) begin
      logic [63:0] rd;
      rd = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) rd = '1;
      cycle($urandom_range(0, 9) < 7, rd, 1'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, rdy);
    end
    repeat (4) cycle(0, 64'h0, 0, 1, 0, rdy);

`ifdef POP_CNT_ACC_EN
    cycle(0, 64'h0, 0, 1, 1, rdy);
    chk("acc_clr0", int'(b32.acc_total), 0);
    repeat (9) cycle(1, 64'hFFFF_FFFF, 0, 1, 0, rdy);
    repeat (4) cycle(0, 64'h0, 0, 1, 0, rdy);
    chk("acc_sat", int'(b32.acc_total), 255);
    cycle(1, 64'h1F, 0, 0, 0, rdy);
    repeat (2) cycle(0, 64'h0, 0, 0, 0, rdy);
    chk("acc_pre", int'(b32.out_count), 5);
    cycle(0, 64'h0, 0, 1, 1, rdy);
    chk("acc_clrx", int'(b32.acc_total), 5);
`else
    chk("acc_off", int'(b32.acc_total), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
